demux12_stream: RTL

- 1-to-2 stream demultiplexer: the inverse of the 2:1 data mux.
- One DATA_W-bit valid/ready input stream is routed by a per-word select to output channel A or B.
- Each channel has a 2-entry FIFO, so a stalled channel never loses data, and per-channel accepted-word counters for debug and status.
- Sits between a shared producer and two independent consumers.

---
 rtl/demux12_stream.sv | 105 ++++++++++
 1 files changed

// File: rtl/demux12_stream.sv
// 1-to-2 valid/ready stream demultiplexer: each input word is steered by i_sel into
// a 2-entry FIFO for channel A or B, with saturating per-channel accepted-word counters.
module demux12_stream #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_sel,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_a_data,
  output logic              o_a_valid,
  input  logic              i_a_ready,
  output logic [DATA_W-1:0] o_b_data,
  output logic              o_b_valid,
  input  logic              i_b_ready,
  output logic [CNT_W-1:0]  o_a_count,
  output logic [CNT_W-1:0]  o_b_count,
  input  logic              i_clr_count
);

  logic [1:0]        full;
  logic [1:0]        head_vld;
  logic [1:0]        cons_rdy;
  logic [DATA_W-1:0] head [2];
  logic [CNT_W-1:0]  cnt  [2];

  assign cons_rdy = {i_b_ready, i_a_ready};

  // Ready looks only at registered occupancy of the selected channel, so a full
  // channel stalls the producer even when the other channel has room.
  assign o_ready = i_sel ? !full[1] : !full[0];

  for (genvar c = 0; c < 2; c++) begin : g_ch
    localparam logic CH_SEL = 1'(c);

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        occ_q;
    logic [1:0]        occ_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              push;
    logic              pop;

    assign push = i_valid & o_ready & (i_sel == CH_SEL);
    assign pop  = (occ_q != 2'd0) & cons_rdy[c];

    always_comb begin
      occ_d = occ_q;
      unique case ({push, pop})
        2'b10:   occ_d = occ_q + 2'd1;
        2'b01:   occ_d = occ_q - 2'd1;
        default: occ_d = occ_q;
      endcase
    end

    // A clear coinciding with a push leaves that push counted.
    always_comb begin
      cnt_d = cnt_q;
      if (i_clr_count) begin
        cnt_d = push ? CNT_W'(1) : '0;
      end else if (push && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        mem_q[0] <= '0;
        mem_q[1] <= '0;
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
        occ_q    <= 2'd0;
        cnt_q    <= '0;
      end else begin
        if (push) begin
          mem_q[wr_ptr_q] <= i_data;
          wr_ptr_q        <= ~wr_ptr_q;
        end
        if (pop) begin
          rd_ptr_q <= ~rd_ptr_q;
        end
        occ_q <= occ_d;
        cnt_q <= cnt_d;
      end
    end

    assign full[c]     = (occ_q == 2'd2);
    assign head_vld[c] = (occ_q != 2'd0);
    assign head[c]     = mem_q[rd_ptr_q];
    assign cnt[c]      = cnt_q;
  end

  assign o_a_data  = head[0];
  assign o_a_valid = head_vld[0];
  assign o_b_data  = head[1];
  assign o_b_valid = head_vld[1];
  assign o_a_count = cnt[0];
  assign o_b_count = cnt[1];

endmodule
